// File: rtl/vx_mem_responder_pkg.sv
// vx_mem_responder_pkg
//   Shared width helpers for the memory responder slice.
//   line_offset_bits : byte-offset bits inside one line (log2 of bytes/line)
//   line_index_bits  : bits of the line address that select a store entry
//   min1_clog2       : log2 that never returns 0, for pointer widths
package vx_mem_responder_pkg;

  function automatic int unsigned line_offset_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int unsigned line_index_bits(input int unsigned mem_lines);
    return $clog2(mem_lines);
  endfunction

  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_mem_responder_fifo_queue.sv
// vx_mem_responder_fifo_queue
//   Small synchronous FIFO used as the response queue. The head entry is
//   presented on data_out whenever empty=0 and stays stable until popped.
//   Ports:
//     clk, reset    clock, asynchronous active-low reset (pointers/count only)
//     push, data_in write one entry (caller guarantees !full)
//     pop           drop the head entry (caller guarantees !empty)
//     data_out      head entry
//     empty, full   occupancy flags
module vx_mem_responder_fifo_queue
  import vx_mem_responder_pkg::*;
#(
  parameter int DATAW = 8,
  parameter int SIZE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = min1_clog2(SIZE);
  localparam int CNT_W = $clog2(SIZE + 1);

  logic [DATAW-1:0] entries [SIZE];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage carries no reset; only the bookkeeping does.
  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign data_out = entries[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(SIZE));

endmodule

// File: rtl/vx_mem_responder.sv
// vx_mem_responder
//   Target end of the cluster memory port. Writes update a line-wide backing
//   store (byte-enabled, never stall); reads snapshot the line at acceptance,
//   travel through LATENCY-1 register stages and land in a response queue
//   whose head drives mem_rsp_*.
//
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both 1. mem_req_ready for reads depends only on the registered credit
//   counter (never on mem_rsp_ready). mem_rsp_data/tag stay stable while
//   mem_rsp_valid=1 and mem_rsp_ready=0.
//
//   Ports:
//     clk, reset                  clock, asynchronous active-low reset
//     mem_req_valid/rw/byteen/size/addr/data/tag, mem_req_ready  request side
//     mem_rsp_valid/data/tag, mem_rsp_ready                      response side
//     busy                        at least one read is in flight
module vx_mem_responder
  import vx_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 32,
  parameter int TAG_WIDTH      = 8,
  parameter int SIZE_WIDTH     = 7,
  parameter int MEM_LINES      = 1024,
  parameter int LATENCY        = 4,
  parameter int RSP_QUEUE_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  input  logic [SIZE_WIDTH-1:0]   mem_req_size,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready,
  output logic                    busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = line_index_bits(MEM_LINES);
  localparam int CRD_W = $clog2(RSP_QUEUE_SIZE + 1);
  localparam int QW    = DATA_WIDTH + TAG_WIDTH;

  logic [CRD_W-1:0]      credits;
  logic [IDX_W-1:0]      line_idx;
  logic [DATA_WIDTH-1:0] store [MEM_LINES];
  logic [DATA_WIDTH-1:0] rd_line;
  logic [DATA_WIDTH-1:0] wr_line;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  rsp_fire;
  logic                  push;
  logic [QW-1:0]         push_data;
  logic [QW-1:0]         head_data;
  logic                  q_empty;
  logic                  q_full;

  // Size is informational only and upper address bits alias onto the store.
  logic unused_req_bits;
  assign unused_req_bits = ^{mem_req_size, mem_req_addr[ADDR_WIDTH-1:IDX_W]};

  assign line_idx = mem_req_addr[IDX_W-1:0];

  // Writes are always accepted out of reset; reads need a free credit.
  assign mem_req_ready = reset && (mem_req_rw || (credits != '0));
  assign wr_fire       = mem_req_valid && mem_req_ready &&  mem_req_rw;
  assign rd_fire       = mem_req_valid && mem_req_ready && !mem_req_rw;
  assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;

  // ---------------- backing store (not reset) ----------------
  assign rd_line = store[line_idx];

  // Merge the enabled bytes into the current line, then write the whole line.
  always_comb begin
    wr_line = rd_line;
    for (int i = 0; i < BYTES; i++) begin
      if (mem_req_byteen[i]) wr_line[i*8 +: 8] = mem_req_data[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) store[line_idx] <= wr_line;
  end

  // ---------------- read pipeline ----------------
  // Capturing rd_line at acceptance freezes the data, so a later write to the
  // same line cannot leak into an older read.
  if (LATENCY == 1) begin : g_no_pipe
    assign push      = rd_fire;
    assign push_data = {mem_req_tag, rd_line};
  end else begin : g_pipe
    localparam int STAGES = LATENCY - 1;
    logic [STAGES-1:0]         pipe_valid;
    logic [STAGES-1:0][QW-1:0] pipe_data;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pipe_valid <= '0;
      end else begin
        pipe_valid[0] <= rd_fire;
        for (int i = 1; i < STAGES; i++) pipe_valid[i] <= pipe_valid[i-1];
      end
    end

    always_ff @(posedge clk) begin
      pipe_data[0] <= {mem_req_tag, rd_line};
      for (int i = 1; i < STAGES; i++) pipe_data[i] <= pipe_data[i-1];
    end

    assign push      = pipe_valid[STAGES-1];
    assign push_data = pipe_data[STAGES-1];
  end

  // ---------------- response queue ----------------
  vx_mem_responder_fifo_queue #(
    .DATAW (QW),
    .SIZE  (RSP_QUEUE_SIZE)
  ) u_rsp_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (rsp_fire),
    .data_in  (push_data),
    .data_out (head_data),
    .empty    (q_empty),
    .full     (q_full)
  );

  assign mem_rsp_valid = !q_empty;
  assign {mem_rsp_tag, mem_rsp_data} = head_data;

  // ---------------- credits ----------------
  // One credit per read from acceptance until its response is taken, which
  // covers both pipeline and queue occupancy; the queue cannot overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits <= CRD_W'(RSP_QUEUE_SIZE);
    end else begin
      case ({rd_fire, rsp_fire})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  assign busy = (credits != CRD_W'(RSP_QUEUE_SIZE));

  always @(posedge clk) begin
    if (reset) begin
      assert (!(push && q_full));
      assert (!(rd_fire && credits == '0));
      assert (!(rsp_fire && credits == CRD_W'(RSP_QUEUE_SIZE)));
    end
  end

endmodule

// File: tb/tb_vx_mem_responder.sv
module tb_vx_mem_responder;

  localparam int DW  = 512;
  localparam int NB  = DW / 8;
  localparam int TW  = 8;
  localparam int LAT = 4;
  localparam int RQ  = 4;
  localparam int NL  = 32;              // lines exercised by the bench
  localparam int EW  = 32 + TW + DW;    // {avail_cycle, tag, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            mem_req_valid;
  logic            mem_req_rw;
  logic [NB-1:0]   mem_req_byteen;
  logic [6:0]      mem_req_size;
  logic [31:0]     mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic [TW-1:0]   mem_req_tag;
  logic            mem_req_ready;
  logic            mem_rsp_valid;
  logic [DW-1:0]   mem_rsp_data;
  logic [TW-1:0]   mem_rsp_tag;
  logic            mem_rsp_ready;
  logic            busy;

  vx_mem_responder dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_size   (mem_req_size),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready),
    .busy           (busy)
  );

  // ---------------- reference model / scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]        mm [NL][NB];       // byte-level model of the store
  logic [EW-1:0]     exp_q[$];          // reads in acceptance order
  logic [TW+DW-1:0]  got_q[$];          // responses taken, {tag, data}

  logic          obs_req_ready, obs_req_fire, obs_rsp_valid, obs_rsp_fire;
  int            obs_cyc;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_line(input int idx);
    logic [DW-1:0] d;
    for (int b = 0; b < NB; b++) d[b*8 +: 8] = mm[idx][b];
    return d;
  endfunction

  function automatic logic [DW-1:0] fill_line(input logic [7:0] fill, input logic [7:0] b0);
    logic [DW-1:0] d;
    d = {NB{fill}};
    d[7:0] = b0;
    return d;
  endfunction

  // One clock cycle: compare outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    logic exp_rdy, exp_rv;
    int   idx;
    @(negedge clk);
    exp_rdy = mem_req_rw ? 1'b1 : (exp_q.size() < RQ);
    exp_rv  = (exp_q.size() > 0) && (int'(exp_q[0][EW-1 -: 32]) <= cyc);
    check("req_ready", DW'(mem_req_ready), DW'(exp_rdy));
    check("rsp_valid", DW'(mem_rsp_valid), DW'(exp_rv));
    check("busy", DW'(busy), DW'(exp_q.size() != 0));
    if (exp_rv && mem_rsp_valid) begin
      check("rsp_tag", DW'(mem_rsp_tag), DW'(exp_q[0][DW +: TW]));
      check("rsp_data", mem_rsp_data, exp_q[0][DW-1:0]);
    end
    obs_req_ready = mem_req_ready;
    obs_rsp_valid = mem_rsp_valid;
    obs_req_fire  = mem_req_valid && exp_rdy;
    obs_rsp_fire  = exp_rv && mem_rsp_ready;
    obs_cyc       = cyc;
    if (obs_rsp_fire) got_q.push_back({mem_rsp_tag, mem_rsp_data});
    @(posedge clk);
    if (obs_rsp_fire) void'(exp_q.pop_front());
    if (obs_req_fire) begin
      idx = int'(mem_req_addr[9:0]);
      if (mem_req_rw) begin
        for (int b = 0; b < NB; b++)
          if (mem_req_byteen[b]) mm[idx][b] = mem_req_data[b*8 +: 8];
      end else begin
        exp_q.push_back({32'(cyc + LAT), mem_req_tag, model_line(idx)});
      end
    end
    cyc++;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic rw, input logic [31:0] a,
                       input logic [NB-1:0] be, input logic [DW-1:0] d, input logic [TW-1:0] t);
    mem_req_valid  = v;
    mem_req_rw     = rw;
    mem_req_addr   = a;
    mem_req_byteen = be;
    mem_req_data   = d;
    mem_req_tag    = t;
    mem_req_size   = 7'($urandom_range(0, 127));
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, '0, '0, '0);
  endtask

  task automatic req_until(input logic rw, input logic [31:0] a, input logic [NB-1:0] be,
                           input logic [DW-1:0] d, input logic [TW-1:0] t);
    logic done;
    done = 1'b0;
    drive(1'b1, rw, a, be, d, t);
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      done = obs_req_fire;
    end
    check("req_accept_timeout", DW'(done), DW'(1));
    idle();
  endtask

  task automatic drain(input int n);
    mem_rsp_ready = 1'b1;
    idle();
    repeat (n) step();
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [63:0] be;
    logic [7:0]  fill;
    logic [7:0]  tag;
    logic        exp_ready;
    logic [7:0]  exp_fill;   // reads: expected bytes 1..63
    logic [7:0]  exp_b0;     // reads: expected byte 0
  } vec_t;

  vec_t tbl [12];

  localparam logic [63:0] ALL = {64{1'b1}};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, lat, seen;
    logic found;
    logic [TW+DW-1:0] g;

    tbl[0]  = '{1'b1, 32'h10,        ALL,   8'hA5, 8'd0, 1'b1, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 32'h10,        '0,    8'h00, 8'd3, 1'b1, 8'hA5, 8'hA5};
    tbl[2]  = '{1'b1, 32'h2,         ALL,   8'h11, 8'd0, 1'b1, 8'h00, 8'h00};
    tbl[3]  = '{1'b1, 32'h2,         64'h1, 8'hFF, 8'd0, 1'b1, 8'h00, 8'h00};
    tbl[4]  = '{1'b0, 32'h2,         '0,    8'h00, 8'd4, 1'b1, 8'h11, 8'hFF};
    tbl[5]  = '{1'b0, 32'h5,         '0,    8'h00, 8'd5, 1'b1, 8'h00, 8'h00};
    tbl[6]  = '{1'b1, 32'h5,         ALL,   8'h77, 8'd0, 1'b1, 8'h00, 8'h00};
    tbl[7]  = '{1'b0, 32'h5,         '0,    8'h00, 8'd6, 1'b1, 8'h77, 8'h77};
    tbl[8]  = '{1'b1, 32'h7,         64'h0, 8'h99, 8'd0, 1'b1, 8'h00, 8'h00};
    tbl[9]  = '{1'b0, 32'h7,         '0,    8'h00, 8'd7, 1'b1, 8'h00, 8'h00};
    tbl[10] = '{1'b0, 32'h4000_0010, '0,    8'h00, 8'd8, 1'b1, 8'hA5, 8'hA5};
    tbl[11] = '{1'b0, 32'h13,        '0,    8'h00, 8'd9, 1'b1, 8'h00, 8'h00};

    // ---- reset state ----
    reset = 1'b0;
    mem_rsp_ready = 1'b1;
    idle();
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b1;
    #12;
    check("reset_req_ready", DW'(mem_req_ready), DW'(0));
    check("reset_rsp_valid", DW'(mem_rsp_valid), DW'(0));
    check("reset_busy", DW'(busy), DW'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle();

    // ---- initialise the lines the bench uses ----
    for (int i = 0; i < NL; i++) req_until(1'b1, 32'(i), ALL, '0, '0);

    // ---- accept-to-response latency ----
    drain(2);
    drive(1'b1, 1'b0, 32'h0, '0, '0, 8'hEE);
    t0 = cyc;
    step();
    idle();
    found = 1'b0;
    lat = -1;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (obs_rsp_valid) begin
        found = 1'b1;
        lat = obs_cyc - t0;
      end
    end
    check("latency", DW'(lat), DW'(LAT));
    drain(4);
    got_q.delete();

    // ---- table-driven directed vectors ----
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, tbl[i].rw, tbl[i].addr, tbl[i].be, {NB{tbl[i].fill}}, tbl[i].tag);
      step();
      check("tbl_ready", DW'(obs_req_ready), DW'(tbl[i].exp_ready));
    end
    drain(12);
    for (int i = 0; i < 12; i++) begin
      if (!tbl[i].rw) begin
        if (got_q.size() == 0) begin
          check("tbl_rsp_missing", DW'(0), DW'(tbl[i].tag));
        end else begin
          g = got_q.pop_front();
          check("tbl_rsp_tag", DW'(g[DW +: TW]), DW'(tbl[i].tag));
          check("tbl_rsp_data", g[DW-1:0], fill_line(tbl[i].exp_fill, tbl[i].exp_b0));
        end
      end
    end

    // ---- backpressure, full-queue stall, simultaneous fire ----
    got_q.delete();
    mem_rsp_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      drive(1'b1, 1'b0, 32'h10, '0, '0, 8'(t));
      step();
      check("bp_accept", DW'(obs_req_fire), DW'(1));
    end
    drive(1'b1, 1'b0, 32'h10, '0, '0, 8'd4);
    repeat (2) begin
      step();
      check("bp_stall", DW'(obs_req_ready), DW'(0));
    end
    drive(1'b1, 1'b1, 32'h3, ALL, {NB{8'h5A}}, 8'd0);
    step();
    check("bp_write", DW'(obs_req_ready), DW'(1));
    drive(1'b1, 1'b0, 32'h3, '0, '0, 8'd4);
    mem_rsp_ready = 1'b1;
    step();
    check("simul_ready", DW'(obs_req_ready), DW'(0));
    check("simul_rsp", DW'(obs_rsp_fire), DW'(1));
    step();
    check("simul_accept", DW'(obs_req_fire), DW'(1));
    req_until(1'b0, 32'h3, '0, '0, 8'd5);
    drain(14);
    check("bp_count", DW'(got_q.size()), DW'(6));
    seen = 0;
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      check("bp_order", DW'(g[DW +: TW]), DW'(seen));
      if (seen >= 4) check("bp_data", g[DW-1:0], {NB{8'h5A}});
      seen++;
    end

    // ---- reset with three reads in flight ----
    for (int t = 0; t < 3; t++) begin
      drive(1'b1, 1'b0, 32'h10, '0, '0, 8'(8'h20 + t));
      step();
    end
    drive(1'b1, 1'b0, 32'h2, '0, '0, 8'h30);
    reset = 1'b0;
    #1;
    check("midrst_req_ready", DW'(mem_req_ready), DW'(0));
    check("midrst_rsp_valid", DW'(mem_rsp_valid), DW'(0));
    check("midrst_busy", DW'(busy), DW'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc++;
    got_q.delete();
    drain(8);
    check("midrst_no_rsp", DW'(got_q.size()), DW'(0));
    for (int t = 0; t < 4; t++) begin
      drive(1'b1, 1'b0, 32'h2, '0, '0, 8'(8'h40 + t));
      mem_rsp_ready = 1'b0;
      step();
      check("midrst_credits", DW'(obs_req_fire), DW'(1));
    end
    drain(10);
    check("midrst_rsp_count", DW'(got_q.size()), DW'(4));
    if (got_q.size() > 0) check("midrst_store_kept", got_q[0][DW-1:0], fill_line(8'h11, 8'hFF));

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 400; n++) begin
      logic [NB-1:0] be;
      int sel;
      sel = $urandom_range(0, 3);
      be  = (sel == 0) ? ALL : (sel == 1) ? '0 : {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0)
        drive(1'b1, 1'($urandom_range(0, 1)),
              ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, NL - 1)),
              be, rand_line(), 8'($urandom_range(0, 255)));
      else
        idle();
      mem_rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain(20);
    check("final_idle", DW'(exp_q.size()), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_mem_responder.md
Name: vx_mem_responder

Overview:
- Target side of the cluster/L2 memory interface. Accepts mem_req_* transactions from a cluster and returns tagged read responses on mem_rsp_*.
- Uses an internal line-wide backing store, a fixed-latency read pipeline and a credit-guarded response queue.
- Serves as the on-chip memory endpoint for simulation and small FPGA builds, sitting directly under the cluster memory port.

Parameters:
- DATA_WIDTH, 512: line width in bits; the number of bytes per line is a power of two.
- ADDR_WIDTH, 32: request address width; addresses are line addresses.
- TAG_WIDTH, 8: request/response tag width.
- SIZE_WIDTH, 7: width of the mem_req_size field.
- MEM_LINES, 1024: backing-store depth in lines; must be a power of two.
- LATENCY, 4: read accept-to-response cycles, when unstalled; must be ≥1.
- RSP_QUEUE_SIZE, 4: response queue depth; also the maximum number of outstanding reads.

Ports:
- clk  in  1  clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_req_valid  in  1  request valid.
- mem_req_rw  in  1  1 = write, 0 = read.
- mem_req_byteen  in  DATA_WIDTH/8  write byte enables.
- mem_req_size  in  SIZE_WIDTH  request size; accepted and ignored (every access is a full line).
- mem_req_addr  in  ADDR_WIDTH  line address.
- mem_req_data  in  DATA_WIDTH  write data.
- mem_req_tag  in  TAG_WIDTH  request tag.
- mem_req_ready  out  1  request accepted when valid&&ready.
- mem_rsp_valid  out  1  read response valid.
- mem_rsp_data  out  DATA_WIDTH  read data.
- mem_rsp_tag  out  TAG_WIDTH  tag of the originating read.
- mem_rsp_ready  in  1  consumer ready.
- busy  out  1  at least one read is in flight.

Behaviour:
- Reset (reset low, asynchronous):
  - mem_req_ready=0, mem_rsp_valid=0, busy=0.
  - Pipeline valids, queue and credit counter are cleared; credits are set to RSP_QUEUE_SIZE.
  - Backing-store contents are not reset.
  - Asserting reset mid-operation drops all in-flight reads without producing responses.
- Indexing: line index = mem_req_addr[log2(MEM_LINES)-1:0]. Upper address bits alias.
- Writes:
  - mem_req_ready is 1 for a write whenever reset is released; writes never stall.
  - On fire, the store is updated for each byte i where byteen[i]=1.
  - Writes produce no response. A write with byteen=0 is a no-op.
- Reads:
  - mem_req_ready is 1 for a read iff credits>0.
  - On fire, the line is read at acceptance time. A later write to the same line does not affect the returned data.
  - Data and tag then pass through LATENCY-1 register stages into the response queue.
  - The queue head drives mem_rsp_*. With an empty queue and mem_rsp_ready=1, a read accepted in cycle T gives mem_rsp_valid=1 in cycle T+LATENCY.
- Ordering: responses return strictly in acceptance order.
- Credits:
  - Decrement on read fire; increment on response fire (mem_rsp_valid&&mem_rsp_ready); unchanged when both happen in the same cycle.
  - Credits count pipeline entries plus queue entries, so the queue can never overflow. Overflow is asserted never to occur.
  - Range is 0..RSP_QUEUE_SIZE; assert no underflow or overflow.
- Response hold: while mem_rsp_valid=1 and mem_rsp_ready=0, mem_rsp_data and mem_rsp_tag are held stable. The pipeline keeps advancing into the queue because the credit guarantees space.
- Full-queue stall: when credits=0, reads stall (ready=0) and writes still proceed.
- Same-cycle events: a read fire and a response fire in the same cycle are both legal.
- busy = credits != RSP_QUEUE_SIZE.
- No combinational path from mem_rsp_ready to mem_req_ready. The credit counter is registered.

Decomposition:
- Shared constants in the common define header: the line-offset and line-index width helpers (CLOG2 of DATA_WIDTH/8 and of MEM_LINES). No typedef package is needed.
- One sub-module: reuse VX_fifo_queue as the response queue, with DATAW = DATA_WIDTH+TAG_WIDTH and SIZE = RSP_QUEUE_SIZE.
- The store, pipeline and credit logic stay in this module.

Test Plan:
- Write then read: write addr 0x10 with data 0xA5 repeated and byteen all-ones; read addr 0x10 with tag 3 accepted at cycle T → mem_rsp_valid at T+4, tag 3, data all 0xA5.
- Partial write: write 0x11..0x11 to line 2 with byteen all-ones, then 0xFF with byteen=0x1 → read of line 2 returns byte0=0xFF and all other bytes 0x11.
- Read-before-write ordering: read line 5 (old 0x00) then write 0x77 the next cycle → the response carries 0x00; a following read returns 0x77.
- Backpressure: hold mem_rsp_ready=0 and issue 6 reads with tags 0..5 → tags 0..3 accepted, ready drops for reads, a write is still accepted. Release ready → tags 0,1,2,3 return in order, then tags 4 and 5 are accepted.
- Simultaneous events: with credits=0, drive a response fire and a read request in the same cycle → the read is accepted the following cycle, and credits never exceed 4 or go below 0.
- Reset mid-flight: 3 reads outstanding, pulse reset low for 1 cycle → no responses appear, busy=0, credits=4, and the store keeps previously written data.
